// File: rtl/conv_filter_sched.sv
// Time-shares one 3x5x5 MAC PE across NUM_FILT filters per window.
// Optional CONV_SCHED_RELU_EN clamps negative activations to zero.
module conv_filter_sched #(
  parameter int NUM_FILT = 8,
  parameter int ACC_W    = 24,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 8,
  parameter int PE_LAT   = 4,
  localparam int FW      = $clog2(NUM_FILT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       win_valid,
  input  logic                       win_last,
  output logic                       win_ready,
  output logic                       wt_rd_en,
  output logic [FW-1:0]              wt_addr,
  output logic                       pe_valid_in,
  input  logic [ACC_W-1:0]           pe_sum,
  input  logic                       pe_valid_out,
  input  logic [NUM_FILT*BIAS_W-1:0] bias_flat,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [FW-1:0]              out_filt,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err
);

  localparam int HW = $clog2(PE_LAT + 2);
  localparam logic signed [ACC_W:0] QMAX =
    (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t            state;
  logic [FW-1:0]     f;
  logic              frame_end;
  logic              last_f;
  logic [PE_LAT:0]   tv;
  logic [PE_LAT:0]   tl;
  logic [FW-1:0]     tf [PE_LAT+1];
  logic [HW-1:0]     hold;
  logic              fire;

  logic signed [BIAS_W-1:0] bias [NUM_FILT];
  logic signed [BIAS_W-1:0] b;
  logic signed [ACC_W:0]    s;
  logic signed [ACC_W:0]    q;
  logic [OUT_W-1:0]         sat;
  logic [OUT_W-1:0]         act;

  assign last_f     = (f == FW'(NUM_FILT - 1));
  assign wt_rd_en   = (state == ISSUE);
  assign wt_addr    = f;
  assign win_ready  = wt_rd_en && last_f;
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE) || (|tv) || out_valid;
  assign fire       = pe_valid_out && tv[PE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      f         <= '0;
      frame_end <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_valid && enable) begin
            state     <= ISSUE;
            f         <= '0;
            frame_end <= win_last;
          end
        end
        ISSUE: begin
          if (last_f) begin
            f     <= '0;
            state <= frame_end ? DRAIN : IDLE;
          end else begin
            f <= f + 1'b1;
          end
        end
        DRAIN: begin
          if (tv == '0) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag stage k lines up with PE operand issued k cycles ago
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_valid_in <= 1'b0;
      tv          <= '0;
      tl          <= '0;
      for (int k = 0; k <= PE_LAT; k++) tf[k] <= '0;
    end else begin
      pe_valid_in <= wt_rd_en;
      tv          <= {tv[PE_LAT-1:0], wt_rd_en};
      tl          <= {tl[PE_LAT-1:0], win_ready};
      tf[0]       <= f;
      for (int k = 1; k <= PE_LAT; k++) tf[k] <= tf[k-1];
    end
  end

  // Stale PE results may land just after reset; ignore them briefly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= HW'(PE_LAT + 1);
      err  <= 1'b0;
    end else if (hold != '0) begin
      hold <= hold - 1'b1;
    end else if (tv[PE_LAT] != pe_valid_out) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FILT; i++)
      bias[i] = bias_flat[i*BIAS_W +: BIAS_W];
    b = bias[tf[PE_LAT]];
    s = $signed({pe_sum[ACC_W-1], pe_sum})
      + $signed({{(ACC_W+1-BIAS_W){b[BIAS_W-1]}}, b});
    q = s >>> SHIFT;
    if (q > QMAX)      sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (q < QMIN) sat = {1'b1, {(OUT_W-1){1'b0}}};
    else               sat = q[OUT_W-1:0];
`ifdef CONV_SCHED_RELU_EN
    act = sat[OUT_W-1] ? '0 : sat;
`else
    act = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_filt  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= fire;
      out_last  <= fire && tl[PE_LAT];
      if (fire) begin
        out_data <= act;
        out_filt <= tf[PE_LAT];
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_sched.sv
// Scoreboard bench for conv_filter_sched with a behavioural PE model.
// Reference: floor((sum+bias)/2^SHIFT), clamped, optional ReLU.
module tb_conv_filter_sched;

  localparam int NF     = 8;
  localparam int ACC_W  = 24;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 8;
  localparam int PE_LAT = 4;
  localparam int FW     = $clog2(NF);

  logic clk, rst_n, enable, win_valid, win_last, win_ready;
  logic wt_rd_en, pe_valid_in, pe_valid_out;
  logic [FW-1:0] wt_addr, out_filt;
  logic [ACC_W-1:0] pe_sum;
  logic [NF*BIAS_W-1:0] bias_flat;
  logic out_valid, out_last, frame_done, busy, err;
  logic [OUT_W-1:0] out_data;

  conv_filter_sched #(
    .NUM_FILT(NF), .ACC_W(ACC_W), .BIAS_W(BIAS_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .win_valid(win_valid), .win_last(win_last),
    .win_ready(win_ready), .wt_rd_en(wt_rd_en),
    .wt_addr(wt_addr), .pe_valid_in(pe_valid_in),
    .pe_sum(pe_sum), .pe_valid_out(pe_valid_out),
    .bias_flat(bias_flat), .out_valid(out_valid),
    .out_data(out_data), .out_filt(out_filt),
    .out_last(out_last), .frame_done(frame_done),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // PE model: one operand per pe_valid_in, result PE_LAT cycles later
  logic [ACC_W-1:0] sum_q[$];
  logic [PE_LAT-1:0] pv = '0;
  logic [ACC_W-1:0] ps [PE_LAT];
  logic inject = 1'b0;

  always @(posedge clk) begin
    for (int k = PE_LAT - 1; k > 0; k--) begin
      pv[k] <= pv[k-1];
      ps[k] <= ps[k-1];
    end
    pv[0] <= pe_valid_in;
    if (pe_valid_in)
      ps[0] <= (sum_q.size() > 0) ? sum_q.pop_front() : '0;
  end

  assign pe_valid_out = pv[PE_LAT-1] | inject;
  assign pe_sum       = ps[PE_LAT-1];

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [FW-1:0]    f;
    logic             l;
  } exp_t;

  exp_t exp_q[$];
  int   out_cycs[$];
  int   wr_cycs[$];
  int   wr_cnt = 0, fd_cnt = 0, rd_cnt = 0;

  longint bias_v[NF];
  longint ws[NF];

  function automatic logic [OUT_W-1:0] ref_act(input longint sum,
                                               input longint bias);
    longint s, q, d, hi, lo;
    d  = longint'(1) << SHIFT;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    s  = sum + bias;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`ifdef CONV_SCHED_RELU_EN
    if (q < 0) q = 0;
`endif
    return OUT_W'(q);
  endfunction

  function automatic longint rnd_sum();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return longint'($signed(r[ACC_W-1:0]));
      1:       return longint'($signed(r[17:0]));
      default: return longint'($signed(r[12:0]));
    endcase
  endfunction

  task automatic apply_bias();
    for (int i = 0; i < NF; i++)
      bias_flat[i*BIAS_W +: BIAS_W] = BIAS_W'(bias_v[i]);
  endtask

  task automatic rand_bias();
    logic [31:0] r;
    for (int i = 0; i < NF; i++) begin
      r = $urandom;
      bias_v[i] = longint'($signed(r[BIAS_W-1:0]));
    end
    apply_bias();
  endtask

  task automatic rand_ws();
    for (int i = 0; i < NF; i++) ws[i] = rnd_sum();
  endtask

  task automatic push_window();
    exp_t e;
    for (int i = 0; i < NF; i++) begin
      sum_q.push_back(ACC_W'(ws[i]));
      e.d = ref_act(ws[i], bias_v[i]);
      e.f = FW'(i);
      e.l = (i == NF - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called on a negedge; returns on the negedge after consumption
  task automatic send_window(input logic last);
    int n;
    push_window();
    win_valid = 1'b1;
    win_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!win_ready && n < 40);
    if (!win_ready) check("win_ready_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (!frame_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 64'(frame_done), 1);
    check("outputs_before_done", 64'(exp_q.size()), 0);
    @(negedge clk);
    check("frame_done_pulse", 64'(frame_done), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_win_ready", 64'(win_ready), 0);
    check("rst_wt_rd_en", 64'(wt_rd_en), 0);
    check("rst_pe_valid_in", 64'(pe_valid_in), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_frame_done", 64'(frame_done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_err", 64'(err), 0);
    check("rst_wt_addr", 64'(wt_addr), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_filt", 64'(out_filt), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (win_ready) begin
      wr_cnt++;
      wr_cycs.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
    if (wt_rd_en) rd_cnt++;
    if (rst_n && out_valid) begin
      out_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_filt", 64'(out_filt), 64'(e.f));
        check("out_last", 64'(out_last), 64'(e.l));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, wr0, fd0, rd0, c0, nw;
    rst_n     = 1'b0;
    enable    = 1'b0;
    win_valid = 1'b0;
    win_last  = 1'b0;
    for (int i = 0; i < NF; i++) bias_v[i] = 0;
    apply_bias();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (8) @(negedge clk);

    // ramp window: out_data = f, latency and win_ready pulse
    for (int i = 0; i < NF; i++) ws[i] = i * 256;
    n0  = out_cycs.size();
    wr0 = wr_cnt;
    fd0 = fd_cnt;
    rd0 = rd_cnt;
    c0  = cyc;
    send_window(1'b0);
    win_valid = 1'b0;
    wait_idle();
    check("first_out_latency", 64'(out_cycs[n0] - c0), 7);
    check("outputs_back_to_back",
          64'(out_cycs[n0+NF-1] - out_cycs[n0]), NF - 1);
    check("win_ready_once", 64'(wr_cnt - wr0), 1);
    check("rd_count", 64'(rd_cnt - rd0), NF);
    check("no_frame_done", 64'(fd_cnt - fd0), 0);
    check("busy_low", 64'(busy), 0);

    // saturation, floor and bias corner values
    for (int i = 0; i < NF; i++) bias_v[i] = 0;
    bias_v[3] = 1;
    apply_bias();
    ws[0] = 100000;
    ws[1] = -100000;
    ws[2] = -1;
    ws[3] = 255;
    ws[4] = 127 * 256 + 255;
    ws[5] = -128 * 256;
    ws[6] = -128 * 256 - 1;
    ws[7] = (1 << (ACC_W - 1)) - 1;
    send_window(1'b0);
    win_valid = 1'b0;
    wait_idle();

    // three-window frame
    rand_bias();
    n0  = wr_cycs.size();
    fd0 = fd_cnt;
    for (int w = 0; w < 3; w++) begin
      rand_ws();
      send_window(w == 2);
    end
    win_valid = 1'b0;
    wait_frame_done();
    check("busy_after_frame", 64'(busy), 0);
    check("win_spacing_0", 64'(wr_cycs[n0+1] - wr_cycs[n0]), NF + 1);
    check("win_spacing_1", 64'(wr_cycs[n0+2] - wr_cycs[n0+1]), NF + 1);
    check("frame_done_count", 64'(fd_cnt - fd0), 1);

    // random frames with random gaps and biases
    for (int fr = 0; fr < 8; fr++) begin
      wait_idle();
      rand_bias();
      fd0 = fd_cnt;
      nw  = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        rand_ws();
        send_window(w == nw - 1);
        if ($urandom_range(0, 1) == 1) begin
          win_valid = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
      end
      win_valid = 1'b0;
      wait_frame_done();
      check("frame_done_rand", 64'(fd_cnt - fd0), 1);
    end
    wait_idle();

    // enable gating
    enable    = 1'b0;
    win_valid = 1'b1;
    win_last  = 1'b0;
    rd0 = rd_cnt;
    repeat (20) @(negedge clk);
    check("enable_low_no_read", 64'(rd_cnt - rd0), 0);
    rand_ws();
    push_window();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("enable_drop_completes", 64'(rd_cnt - rd0), NF);
    win_valid = 1'b0;
    wait_idle();
    enable = 1'b1;
    check("err_clean", 64'(err), 0);

    // spurious PE result
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    check("err_set", 64'(err), 1);
    repeat (10) @(negedge clk);
    check("err_sticky", 64'(err), 1);

    // reset in the middle of ISSUE
    rand_ws();
    push_window();
    win_valid = 1'b1;
    win_last  = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_issue", 64'(wt_rd_en), 1);
    rst_n     = 1'b0;
    win_valid = 1'b0;
    win_last  = 1'b0;
    sum_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("err_after_reset", 64'(err), 0);
    check("busy_after_reset", 64'(busy), 0);

    // recovery frame
    rand_bias();
    fd0 = fd_cnt;
    rand_ws();
    send_window(1'b1);
    win_valid = 1'b0;
    wait_frame_done();
    check("frame_done_recover", 64'(fd_cnt - fd0), 1);
    check("err_final", 64'(err), 0);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
